mdc_delay_ctrl_16pt: RTL and testbench
======================================

Name: mdc_delay_ctrl_16pt

Overview:
- Upstream feeder for the 16-point stage-2 commutator in the 32-point MDC IFFT pipeline.
- Takes the upper and lower butterfly outputs of stage 1 (S2.9, 12-bit complex).
- Delays the lower branch by DEPTH valid samples and registers the upper branch by one cycle.
- Generates the commutator's per-sample control_signal (1 = bypass, 0 = switch), together with an output valid.

Parameters:
- DW, 12, sample width per real/imag component (S2.9 two's complement).
- DEPTH, 8, lower-branch delay in valid samples; power of two, at least 2.
- CW, 4, phase-counter width, equal to log2(2*DEPTH).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of counters, fill state and delay line; data outputs hold.
- in_valid  input  1  UI/LI carry a sample this cycle; the pipeline advances only when this is high.
- UI_real, UI_imag  input  DW each  upper-branch sample.
- LI_real, LI_imag  input  DW each  lower-branch sample.
- UO_real, UO_imag  output  DW each  registered upper sample.
- LO_real, LO_imag  output  DW each  lower sample delayed by DEPTH valid samples.
- control_signal  output  1  commutator select for the current output pair: 1 = bypass, 0 = switch.
- out_valid  output  1  output pair valid and delay line primed.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs are 0.
  - Delay-line entries, phase counter and fill counter are 0.
  - Reset takes effect immediately, including mid-frame. After release the block restarts as if it has never run.
- Internal state:
  - DEPTH-entry complex delay line for LI.
  - Phase counter ph, CW bits, wraps from 2*DEPTH-1 to 0.
  - Fill counter fill, 0..DEPTH, saturates at DEPTH.
- Accepted sample (in_valid = 1, clr = 0), all registered, latency 1 clock:
  - UO_* <= UI_*.
  - LO_* <= oldest delay entry, i.e. the LI value accepted DEPTH valid samples earlier (0 while not yet filled).
  - LI shifts into the newest entry.
  - control_signal <= 1 if ph < DEPTH, else 0.
  - ph <= ph + 1 mod 2*DEPTH.
  - out_valid <= 1 iff fill == DEPTH before this sample; then fill <= min(fill + 1, DEPTH).
- Idle cycle (in_valid = 0, clr = 0):
  - out_valid <= 0.
  - UO, LO, control_signal, delay line, ph and fill hold.
  - Gaps of any length are transparent: delay and phase are counted in valid samples, not cycles.
- clr = 1 (takes priority over in_valid):
  - ph, fill and all delay entries <= 0; out_valid <= 0; control_signal <= 0.
  - UO and LO hold.
  - A sample presented on the clr cycle is dropped.
- Phase alignment:
  - Accepted sample index k counts from 0 after reset or clr.
  - control for sample k is 1 when (k mod 2*DEPTH) < DEPTH.
  - The first out_valid is at k = DEPTH, with control_signal = 0 (switch). The downstream commutator therefore exchanges the delayed lower and undelayed upper branches in alternating blocks of DEPTH.
- No arithmetic is performed: values pass bit-exact, with no rounding or saturation.

Test Plan:
- Reset: hold rst_n low, drive random inputs with in_valid = 1 -> all outputs 0. Release rst_n, drive nothing -> outputs stay 0.
- Fill and delay: 24 consecutive valid samples k = 0..23, with UI_real = 100+k and LI_real = k (imag = -k) ->
  - One cycle after sample k: UO_real = 100+k.
  - For k >= 8: LO_real = k-8 and LO_imag = -(k-8).
  - For k < 8: LO = 0 and out_valid = 0.
  - out_valid first rises for k = 8.
- Control and wrap: same run -> control_signal is 1 for k = 0..7, 0 for 8..15, 1 for 16..23. ph wraps from 15 to 0 with no glitch.
- Stall: after 10 samples, insert 5 cycles with in_valid = 0, then continue ->
  - out_valid is 0 during the gap and outputs hold.
  - Sample 10 yields LO_real = 2 and control = 0, identical to the gapless run.
- clr mid-frame: at sample 12, assert clr with in_valid = 1 ->
  - That sample is dropped; out_valid = 0.
  - The next 8 samples produce out_valid = 0 and LO = 0.
  - Control restarts at 1.
- Async reset mid-operation: pulse rst_n low between clock edges at sample 13 -> outputs go to 0 before the next edge, and the subsequent run matches the fresh-reset sequence.

Source files
------------

// File: rtl/mdc_delay_ctrl_16pt.sv
// Upstream feeder for the 16-point stage-2 commutator of the 32-point MDC IFFT.
// The lower branch is delayed by DEPTH accepted samples, and the upper branch is
// registered once. The block also generates the per-sample commutator control
// (1 = bypass, 0 = switch) and an output valid that rises once the delay line
// is primed. Samples pass through bit-exact. Delay and phase advance only on
// accepted samples, so gaps in in_valid have no effect on the sequence.
module mdc_delay_ctrl_16pt #(
    parameter int DW    = 12,  // bits per real/imag component (S2.9)
    parameter int DEPTH = 8,   // lower-branch delay; power of two, >= 2
    parameter int CW    = 4    // log2(2*DEPTH), phase counter width
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [DW-1:0] UI_real,
    input  logic [DW-1:0] UI_imag,
    input  logic [DW-1:0] LI_real,
    input  logic [DW-1:0] LI_imag,
    output logic [DW-1:0] UO_real,
    output logic [DW-1:0] UO_imag,
    output logic [DW-1:0] LO_real,
    output logic [DW-1:0] LO_imag,
    output logic          control_signal,
    output logic          out_valid
);

    // The fill counter saturates at DEPTH, and that value fits in CW bits
    // because 2*DEPTH == 2**CW.
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] PH_LAST = CW'(2 * DEPTH - 1);

    // Entry 0 holds the newest sample. Entry DEPTH-1 holds the oldest.
    logic [DW-1:0] dl_real [DEPTH];
    logic [DW-1:0] dl_imag [DEPTH];

    logic [CW-1:0] ph;
    logic [CW-1:0] fill;
    logic          accept;

    // A clear overrides in_valid, so a sample presented with clr is dropped.
    assign accept = in_valid & ~clr;

    // Delay line: shift on each accepted sample, and zero it on clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                dl_real[i] <= '0;
                dl_imag[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                dl_real[i] <= '0;
                dl_imag[i] <= '0;
            end
        end else if (accept) begin
            dl_real[0] <= LI_real;
            dl_imag[0] <= LI_imag;
            for (int i = 1; i < DEPTH; i++) begin
                dl_real[i] <= dl_real[i-1];
                dl_imag[i] <= dl_imag[i-1];
            end
        end
    end

    // Phase counter: wraps every 2*DEPTH samples. Fill counter: saturates at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph   <= '0;
            fill <= '0;
        end else if (clr) begin
            ph   <= '0;
            fill <= '0;
        end else if (accept) begin
            ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
            if (fill != DEPTH_C) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // Registered outputs. The data outputs hold on idle and clr cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            UO_real        <= '0;
            UO_imag        <= '0;
            LO_real        <= '0;
            LO_imag        <= '0;
            control_signal <= 1'b0;
            out_valid      <= 1'b0;
        end else if (clr) begin
            control_signal <= 1'b0;
            out_valid      <= 1'b0;
        end else if (accept) begin
            UO_real        <= UI_real;
            UO_imag        <= UI_imag;
            LO_real        <= dl_real[DEPTH-1];
            LO_imag        <= dl_imag[DEPTH-1];
            control_signal <= (ph < DEPTH_C);
            out_valid      <= (fill == DEPTH_C);
        end else begin
            out_valid      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mdc_delay_ctrl_16pt.sv
// Self-checking bench for mdc_delay_ctrl_16pt. It has three parts:
// - a table of the gapless 24-sample run, checked against hand-derived values;
// - hand-written stall, clr and async-reset sequences;
// - a randomized run checked against a queue-based reference model.
module tb_mdc_delay_ctrl_16pt;

    localparam int DW    = 12;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int NTAB  = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic [DW-1:0] UI_real, UI_imag, LI_real, LI_imag;
    logic [DW-1:0] UO_real, UO_imag, LO_real, LO_imag;
    logic          control_signal;
    logic          out_valid;

    always #5 clk = ~clk;

    mdc_delay_ctrl_16pt #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (clr),
        .in_valid       (in_valid),
        .UI_real        (UI_real),
        .UI_imag        (UI_imag),
        .LI_real        (LI_real),
        .LI_imag        (LI_imag),
        .UO_real        (UO_real),
        .UO_imag        (UO_imag),
        .LO_real        (LO_real),
        .LO_imag        (LO_imag),
        .control_signal (control_signal),
        .out_valid      (out_valid)
    );

    // Vector layout: {UO_real, UO_imag, LO_real, LO_imag, control, out_valid}
    typedef struct {
        logic [DW-1:0]     ur;
        logic [DW-1:0]     ui;
        logic [DW-1:0]     lr;
        logic [DW-1:0]     li;
        logic [4*DW+1:0]   exp;
    } vec_t;

    vec_t tbl [NTAB];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state. q_* holds the last DEPTH accepted lower samples.
    logic [DW-1:0] m_uo_r, m_uo_i, m_lo_r, m_lo_i;
    logic          m_ctrl, m_ov;
    logic [DW-1:0] q_r [$];
    logic [DW-1:0] q_i [$];
    int            m_k;

    function automatic logic [4*DW+1:0] dut_vec();
        return {UO_real, UO_imag, LO_real, LO_imag, control_signal, out_valid};
    endfunction

    function automatic logic [4*DW+1:0] model_vec();
        return {m_uo_r, m_uo_i, m_lo_r, m_lo_i, m_ctrl, m_ov};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic model_reset();
        m_uo_r = '0; m_uo_i = '0; m_lo_r = '0; m_lo_i = '0;
        m_ctrl = 1'b0; m_ov = 1'b0;
        q_r.delete(); q_i.delete();
        m_k = 0;
    endtask

    task automatic model_step(input logic v, input logic c,
                              input logic [DW-1:0] ur, input logic [DW-1:0] ui,
                              input logic [DW-1:0] lr, input logic [DW-1:0] li);
        if (c) begin
            q_r.delete(); q_i.delete();
            m_k = 0; m_ov = 1'b0; m_ctrl = 1'b0;
        end else if (v) begin
            m_uo_r = ur; m_uo_i = ui;
            if (q_r.size() == DEPTH) begin
                m_lo_r = q_r.pop_front();
                m_lo_i = q_i.pop_front();
            end else begin
                m_lo_r = '0; m_lo_i = '0;
            end
            m_ctrl = ((m_k % (2 * DEPTH)) < DEPTH);
            m_ov   = (m_k >= DEPTH);
            q_r.push_back(lr);
            q_i.push_back(li);
            m_k++;
        end else begin
            m_ov = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, advance the model, and sample 1 time unit after the edge.
    task automatic cycle(input logic v, input logic c,
                         input logic [DW-1:0] ur, input logic [DW-1:0] ui,
                         input logic [DW-1:0] lr, input logic [DW-1:0] li);
        in_valid = v; clr = c;
        UI_real = ur; UI_imag = ui; LI_real = lr; LI_imag = li;
        model_step(v, c, ur, ui, lr, li);
        @(posedge clk);
        #1;
        $display("t=%0t v=%0b clr=%0b UO=%h/%h LO=%h/%h ctrl=%0b ov=%0b",
                 $time, v, c, UO_real, UO_imag, LO_real, LO_imag, control_signal, out_valid);
    endtask

    // Accepted sample k of the reference pattern: UI = 100+k / 200+k, LI = k / -k.
    task automatic pattern(input int k);
        cycle(1'b1, 1'b0, DW'(100 + k), DW'(200 + k), DW'(k), DW'(-k));
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < NTAB; i++) begin
            cycle(1'b1, 1'b0, tbl[i].ur, tbl[i].ui, tbl[i].lr, tbl[i].li);
            check($sformatf("%s_k%0d", tag, i), 64'(dut_vec()), 64'(tbl[i].exp));
        end
    endtask

    initial begin
        // Table of the gapless run. The expectations come straight from the delay/phase rules.
        for (int k = 0; k < NTAB; k++) begin
            logic [DW-1:0] elr, eli;
            elr = (k >= DEPTH) ? DW'(k - DEPTH) : '0;
            eli = (k >= DEPTH) ? DW'(DEPTH - k) : '0;
            tbl[k].ur  = DW'(100 + k);
            tbl[k].ui  = DW'(200 + k);
            tbl[k].lr  = DW'(k);
            tbl[k].li  = DW'(-k);
            tbl[k].exp = {DW'(100 + k), DW'(200 + k), elr, eli,
                          1'((k % 16) < 8), 1'(k >= DEPTH)};
        end

        // Reset held with active random inputs: all outputs must stay 0.
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
        UI_real = '0; UI_imag = '0; LI_real = '0; LI_imag = '0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            UI_real = DW'($urandom); UI_imag = DW'($urandom);
            LI_real = DW'($urandom); LI_imag = DW'($urandom);
            @(posedge clk); #1;
            check($sformatf("reset_hold%0d", i), 64'(dut_vec()), 64'(0));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, '0, '0, '0, '0);
            check($sformatf("reset_idle%0d", i), 64'(dut_vec()), 64'(0));
        end

        // Fill, delay, control and phase wrap
        run_table("fill");

        // Stall: clear, run 10 samples, leave a 5-cycle gap, then continue.
        cycle(1'b0, 1'b1, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
        check("clr_model", 64'(dut_vec()), 64'(model_vec()));
        check("clr_hold_uo", 64'(UO_real), 64'(DW'(123)));
        for (int k = 0; k < 10; k++) begin
            pattern(k);
            check($sformatf("stall_pre_k%0d", k), 64'(dut_vec()), 64'(model_vec()));
        end
        for (int g = 0; g < 5; g++) begin
            cycle(1'b0, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
            check($sformatf("gap_ov%0d", g), 64'(out_valid), 64'(0));
            check($sformatf("gap_hold%0d", g), 64'({UO_real, LO_real}), 64'({DW'(109), DW'(1)}));
        end
        pattern(10);
        check("stall_k10", 64'({LO_real, control_signal, out_valid}), 64'({DW'(2), 1'b0, 1'b1}));
        pattern(11);
        check("stall_k11", 64'(dut_vec()), 64'(model_vec()));

        // clr mid-frame at sample 12, with in_valid also high
        cycle(1'b1, 1'b1, DW'(112), DW'(212), DW'(12), DW'(-12));
        check("clr12", 64'({LO_real, UO_real, control_signal, out_valid}),
              64'({DW'(3), DW'(111), 1'b0, 1'b0}));
        for (int k = 0; k < 8; k++) begin
            pattern(k);
            check($sformatf("postclr_k%0d", k), 64'({LO_real, LO_imag, out_valid}), 64'(0));
            if (k == 0) check("postclr_ctrl", 64'(control_signal), 64'(1));
        end
        for (int k = 8; k < 13; k++) begin
            pattern(k);
            check($sformatf("postclr_k%0d", k), 64'(dut_vec()), 64'(model_vec()));
        end

        // Async reset pulse between clock edges at sample 13
        in_valid = 1'b1; UI_real = DW'(113); LI_real = DW'(13);
        #3 rst_n = 1'b0; in_valid = 1'b0;
        #1 check("async_rst", 64'(dut_vec()), 64'(0));
        model_reset();
        #1 rst_n = 1'b1;
        run_table("rerun");

        // Randomized traffic checked against the reference model
        for (int n = 0; n < 900; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (n % 300 == 299) begin
                #2 rst_n = 1'b0;
                #1 check($sformatf("rand_rst%0d", n), 64'(dut_vec()), 64'(0));
                model_reset();
                rst_n = 1'b1;
            end
            cycle(r < 70, r >= 97, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
            check($sformatf("rand%0d", n), 64'(dut_vec()), 64'(model_vec()));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
